// File: rtl/retry_lock_pkg.sv
// Shared types and helpers for the retry/backoff lock responder.
package retry_lock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1
  } lock_state_e;

  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/retry_lock_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping around.
module rr_pick
  import retry_lock_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic              valid,
  output logic [IdxW-1:0]   idx
);

  // Wrap-around priority scan; the first hit along the scan order sticks
  always_comb begin
    logic [IdxW-1:0] cand_s;
    logic            hit_s;
    valid  = 1'b0;
    idx    = {IdxW{1'b0}};
    cand_s = {IdxW{1'b0}};
    hit_s  = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      cand_s = IdxW'((int'(ptr) + k) % NumReq);
      hit_s  = !valid && req[cand_s];
      idx    = hit_s ? cand_s : idx;
      valid  = valid | req[cand_s];
    end
  end

endmodule

// File: rtl/retry_lock_arbiter.sv
// Responder for the retry/backoff lock protocol: round-robin grant, ACK/NACK
// responses one cycle after each sampled request, watchdog-forced release.
module retry_lock_arbiter_chk #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 256
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic [NumReq-1:0] rsp_valid,
  input logic [NumReq-1:0] rsp_ok
);

  if (NumReq < 1) begin : g_bad_num_req
    $error("retry_lock_arbiter: NumReq must be >= 1");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("retry_lock_arbiter: TimeoutCycles must be >= 2");
  end

  a_ok_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rsp_ok));
  a_ok_valid   : assert property (@(posedge clk_i) disable iff (!rst_ni) ((rsp_ok & ~rsp_valid) == '0));

endmodule

module retry_lock_arbiter
  import retry_lock_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              rel_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  output logic [NumReq-1:0]              rsp_ok_o,
  output logic                           locked_o,
  output logic [idx_width(NumReq)-1:0]   owner_o,
  output logic                           timeout_o
);

  localparam int IdxW = idx_width(NumReq);
  localparam int CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutCycles - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumReq - 1);

  lock_state_e       state_r, state_s;
  logic [IdxW-1:0]   owner_r, owner_s;
  logic [IdxW-1:0]   ptr_r, ptr_s;
  logic [CntW-1:0]   cnt_r, cnt_s;
  logic              timeout_r, timeout_s;
  logic [NumReq-1:0] rsp_valid_r, rsp_ok_r, rsp_ok_s;
  logic [NumReq-1:0] owner_hot_s, pick_hot_s;
  logic              pick_valid_s;
  logic [IdxW-1:0]   pick_idx_s;
  logic              owner_rel_s;

  rr_pick #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_rr_pick (
    .req  (req_i),
    .ptr  (ptr_r),
    .valid(pick_valid_s),
    .idx  (pick_idx_s)
  );

  // One-hot decode of the current owner and of the round-robin winner
  always_comb begin
    owner_hot_s = {NumReq{1'b0}};
    pick_hot_s  = {NumReq{1'b0}};
    for (int i = 0; i < NumReq; i++) begin
      owner_hot_s[i] = (owner_r == IdxW'(i));
      pick_hot_s[i]  = pick_valid_s && (pick_idx_s == IdxW'(i));
    end
  end

  assign owner_rel_s = rel_i[owner_r];

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      owner_r     <= {IdxW{1'b0}};
      ptr_r       <= {IdxW{1'b0}};
      cnt_r       <= {CntW{1'b0}};
      timeout_r   <= 1'b0;
      rsp_valid_r <= {NumReq{1'b0}};
      rsp_ok_r    <= {NumReq{1'b0}};
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      ptr_r       <= ptr_s;
      cnt_r       <= cnt_s;
      timeout_r   <= timeout_s;
      rsp_valid_r <= req_i;
      rsp_ok_r    <= rsp_ok_s;
    end
  end

  // Next-state logic; an owner release beats a same-cycle watchdog expiry
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s = LOCKED;
          owner_s = pick_idx_s;
          ptr_s   = (pick_idx_s == LastIdx) ? {IdxW{1'b0}} : pick_idx_s + IdxW'(1);
          cnt_s   = {CntW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      LOCKED: begin
        if (owner_rel_s) begin
          state_s = IDLE;
        end else if (cnt_r == CntLast) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CntW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Response decision, judged against the state at the sampling cycle
  always_comb begin
    rsp_ok_s = {NumReq{1'b0}};
    case (state_r)
      IDLE:    rsp_ok_s = pick_hot_s;
      LOCKED:  rsp_ok_s = req_i & owner_hot_s;
      default: rsp_ok_s = {NumReq{1'b0}};
    endcase
  end

  assign rsp_valid_o = rsp_valid_r;
  assign rsp_ok_o    = rsp_ok_r;
  assign locked_o    = (state_r == LOCKED);
  assign owner_o     = owner_r;
  assign timeout_o   = timeout_r;

  retry_lock_arbiter_chk #(
    .NumReq       (NumReq),
    .TimeoutCycles(TimeoutCycles)
  ) u_chk (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .rsp_valid(rsp_valid_o),
    .rsp_ok   (rsp_ok_o)
  );

endmodule

// File: tb/tb_retry_lock_arbiter.sv
// Scoreboard bench for retry_lock_arbiter: a reference model pushes expected
// responses when requests are driven; they are popped and compared a cycle later.
module tb_retry_lock_arbiter;

  localparam int N = 4;
  localparam int T = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] req_i, rel_i;
  logic [N-1:0] rsp_valid_o, rsp_ok_o;
  logic         locked_o, timeout_o;
  logic [1:0]   owner_o;

  retry_lock_arbiter #(.NumReq(N), .TimeoutCycles(T)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .rel_i      (rel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ok_o   (rsp_ok_o),
    .locked_o   (locked_o),
    .owner_o    (owner_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [N-1:0] v;
    logic [N-1:0] ok;
  } rsp_t;

  rsp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  bit   m_locked;
  int   m_owner, m_ptr, m_cnt;
  bit   m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus, predict, then compare right after the edge
  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] rel);
    rsp_t e;
    int   w;
    req_i = req;
    rel_i = rel;
    e.v   = req;
    e.ok  = '0;
    w     = -1;
    if (!m_locked) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) e.ok[w] = 1'b1;
    end else if (req[m_owner]) begin
      e.ok[m_owner] = 1'b1;
    end
    sb_q.push_back(e);
    m_to = 1'b0;
    if (!m_locked) begin
      if (w >= 0) begin
        m_locked = 1'b1; m_owner = w; m_ptr = (w + 1) % N; m_cnt = 0;
      end
    end else if (rel[m_owner]) begin
      m_locked = 1'b0;
    end else if (m_cnt == T - 1) begin
      m_locked = 1'b0; m_to = 1'b1;
    end else begin
      m_cnt++;
    end
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("rsp_valid", 32'(rsp_valid_o), 32'(e.v));
      check("rsp_ok", 32'(rsp_ok_o), 32'(e.ok));
    end
    check("locked", 32'(locked_o), 32'(m_locked));
    check("timeout", 32'(timeout_o), 32'(m_to));
    if (m_locked) check("owner", 32'(owner_o), 32'(m_owner));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    rel_i  = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  int acks[N];
  int bo[N], ex[N], hold[N];
  bit got[N];
  logic [N-1:0] rq, rl;

  initial begin
    do_reset();
    #1;
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_owner", 32'(owner_o), 32'd0);
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_ok", 32'(rsp_ok_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);

    // Single request from 1 is granted
    cycle(4'b0010, 4'b0000);
    check("t1_valid", 32'(rsp_valid_o), 32'h2);
    check("t1_ok", 32'(rsp_ok_o), 32'h2);
    cycle(4'b0000, 4'b0000);
    check("t1_locked", 32'(locked_o), 32'd1);
    check("t1_owner", 32'(owner_o), 32'd1);

    // Contenders are NACKed; stray releases are ignored
    cycle(4'b1101, 4'b0000);
    check("t2_ok", 32'(rsp_ok_o), 32'h0);
    cycle(4'b0000, 4'b0100);
    check("t2_nonowner_rel", 32'(locked_o), 32'd1);
    cycle(4'b0000, 4'b0010);
    check("t2_released", 32'(locked_o), 32'd0);
    cycle(4'b0000, 4'b1111);
    check("t2_idle_rel", 32'(locked_o), 32'd0);

    // Round-robin fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) acks[i] = 0;
    for (int g = 0; g < 5; g++) begin
      cycle(4'b1111, 4'b0000);
      check("t3_owner", 32'(owner_o), 32'(g % N));
      if (g < N) for (int i = 0; i < N; i++) acks[i] += int'(rsp_ok_o[i]);
      cycle(4'b1111 & ~(4'b0001 << (g % N)), 4'b0001 << (g % N));
      if (g < N) for (int i = 0; i < N; i++) acks[i] += int'(rsp_ok_o[i]);
    end
    for (int i = 0; i < N; i++) check("t3_acks", 32'(acks[i]), 32'd1);

    // Request colliding with owner release is NACKed, wins next cycle
    cycle(4'b0100, 4'b0000);
    cycle(4'b0001, 4'b0100);
    check("t5_coll_ok", 32'(rsp_ok_o), 32'h0);
    cycle(4'b0001, 4'b0000);
    check("t5_next_ok", 32'(rsp_ok_o), 32'h1);
    // Owner re-request with release: ACK, but lock still drops
    cycle(4'b0001, 4'b0001);
    check("t5_reent_ok", 32'(rsp_ok_o), 32'h1);
    check("t5_reent_locked", 32'(locked_o), 32'd0);

    // Watchdog expiry
    cycle(4'b0100, 4'b0000);
    for (int k = 1; k < T; k++) cycle(4'b0000, 4'b0000);
    check("t4_pre_timeout", 32'(timeout_o), 32'd0);
    cycle(4'b0000, 4'b0000);
    check("t4_timeout", 32'(timeout_o), 32'd1);
    check("t4_unlocked", 32'(locked_o), 32'd0);
    cycle(4'b1000, 4'b0000);
    check("t4_req3_ok", 32'(rsp_ok_o), 32'h8);
    check("t4_pulse_end", 32'(timeout_o), 32'd0);
    cycle(4'b0000, 4'b1000);

    // Release on the expiry cycle suppresses the timeout pulse
    cycle(4'b0010, 4'b0000);
    for (int k = 1; k < T; k++) cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0010);
    check("t5_rel_expiry", 32'(timeout_o), 32'd0);
    cycle(4'b0000, 4'b0000);
    check("t5_rel_expiry_after", 32'(timeout_o), 32'd0);

    // Reset while locked with responses pending
    cycle(4'b0001, 4'b0000);
    cycle(4'b1111, 4'b0000);
    check("t6_pending", 32'(rsp_valid_o), 32'hf);
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("t6_valid", 32'(rsp_valid_o), 32'h0);
    check("t6_locked", 32'(locked_o), 32'd0);
    check("t6_ok", 32'(rsp_ok_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(4'b1111, 4'b0000);
    check("t6_grant0", 32'(rsp_ok_o), 32'h1);
    cycle(4'b0000, 4'b0001);

    // Closed loop with per-initiator exponential backoff
    for (int i = 0; i < N; i++) begin bo[i] = 0; ex[i] = 0; hold[i] = 0; got[i] = 1'b0; end
    for (int n = 0; n < 400; n++) begin
      rq = '0;
      rl = '0;
      for (int i = 0; i < N; i++) begin
        if (hold[i] > 0) rl[i] = (hold[i] == 1);
        else if (bo[i] == 0) rq[i] = 1'b1;
      end
      cycle(rq, rl);
      for (int i = 0; i < N; i++) begin
        if (hold[i] > 0) hold[i]--;
        else if (bo[i] > 0) bo[i]--;
        if (rsp_valid_o[i]) begin
          if (rsp_ok_o[i]) begin
            got[i] = 1'b1; ex[i] = 0; bo[i] = 0; hold[i] = 3;
          end else begin
            ex[i] = (ex[i] < 4) ? ex[i] + 1 : 4;
            bo[i] = int'($urandom_range(1, 1 << ex[i]));
          end
        end
      end
    end
    for (int i = 0; i < N; i++) check("cl_got_ack", 32'(got[i]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
